// File: rtl/wb_scoreboard_pkg.sv
// Shared definitions for the writeback scoreboard: failure cause codes and FSM states.
package wb_sb_pkg;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_UNEXP    = 2'd1;
    localparam logic [1:0] CAUSE_MISMATCH = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FINISH = 2'd2
    } sb_state_e;

endpackage

// File: rtl/wb_scoreboard_if.sv
// Bundle of the expected-result feed, the tapped writeback port and the verdict outputs.
interface wb_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16
);
    logic                     exp_valid;
    logic                     exp_ready;
    logic [REG_AW-1:0]        exp_rd;
    logic [XLEN-1:0]          exp_data;
    logic                     wb_en;
    logic [REG_AW-1:0]        wb_rd;
    logic [XLEN-1:0]          wb_data;
    logic                     done;
    logic [$clog2(DEPTH):0]   pending;
    logic [15:0]              err_count;
    logic [1:0]               fail_cause;
    logic [REG_AW-1:0]        fail_rd;
    logic [XLEN-1:0]          fail_exp;
    logic [XLEN-1:0]          fail_got;
    logic                     pass;
    logic                     fail;

    // Stimulus / bench side.
    modport master (
        output exp_valid, exp_rd, exp_data, wb_en, wb_rd, wb_data, done,
        input  exp_ready, pending, err_count, fail_cause, fail_rd, fail_exp, fail_got, pass, fail
    );

    // Scoreboard side.
    modport slave (
        input  exp_valid, exp_rd, exp_data, wb_en, wb_rd, wb_data, done,
        output exp_ready, pending, err_count, fail_cause, fail_rd, fail_exp, fail_got, pass, fail
    );
endinterface

// File: rtl/wb_scoreboard_fifo.sv
// Synchronous FIFO of expected {rd, data} entries with occupancy count and flush.
module sb_fifo #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [REG_AW-1:0]      i_rd,
    input  logic [XLEN-1:0]        i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [REG_AW-1:0]      o_rd,
    output logic [XLEN-1:0]        o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [REG_AW-1:0] r_mem_rd   [DEPTH];
    logic [XLEN-1:0]   r_mem_data [DEPTH];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     r_rp;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    // A flush discards the whole queue, including anything offered that cycle.
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rd    = r_mem_rd[r_rp];
    assign o_data  = r_mem_data[r_rp];

    // Storage array; contents are qualified by the count, so no reset needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wp]   <= i_rd;
            r_mem_data[r_wp] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/wb_scoreboard.sv
// In-order writeback scoreboard: checks each retiring register write against the
// head of an expected-result queue, captures the first failure and flags hangs.
module wb_scoreboard
    import wb_sb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 64,
    parameter bit IGNORE_X0 = 1'b1
) (
    input logic           clk,
    input logic           rst,
    wb_scoreboard_if.slave sb
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_RUN    = RUN;
    localparam logic [1:0] S_DRAIN  = DRAIN;
    localparam logic [1:0] S_FINISH = FINISH;

    logic [1:0]        r_state;
    logic [TW-1:0]     r_tmo;
    logic [15:0]       r_err_count;
    logic [1:0]        r_fail_cause;
    logic [REG_AW-1:0] r_fail_rd;
    logic [XLEN-1:0]   r_fail_exp;
    logic [XLEN-1:0]   r_fail_got;
    logic              r_pass;
    logic              r_fail;

    logic              w_event;
    logic              w_finish;
    logic              w_push;
    logic              w_pop;
    logic              w_unexp;
    logic              w_mismatch;
    logic              w_tmo_run;
    logic              w_tmo_hit;
    logic              w_err;
    logic              w_drained;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [REG_AW-1:0] w_head_rd;
    logic [XLEN-1:0]   w_head_data;

    assign w_event  = sb.wb_en && !(IGNORE_X0 && (sb.wb_rd == '0));
    assign w_finish = (r_state == S_FINISH);

    assign sb.exp_ready = !w_full && !w_finish && !rst;
    assign w_push       = sb.exp_valid && sb.exp_ready;

    // No bypass: a write on an empty queue is unexpected even if an entry arrives with it.
    assign w_pop      = w_event && !w_empty && !w_finish;
    assign w_unexp    = w_event && (w_empty || w_finish);
    assign w_mismatch = w_pop && ((sb.wb_rd != w_head_rd) || (sb.wb_data != w_head_data));

    // Fire on the cycle the idle counter would step to TIMEOUT, so it never holds that value.
    assign w_tmo_run = !w_empty && !w_event;
    assign w_tmo_hit = w_tmo_run && (r_tmo == TW'(TIMEOUT - 1));
    assign w_err     = w_unexp || w_mismatch || w_tmo_hit;

    // Queue becomes empty at this edge (flush, last pop, or already empty with nothing arriving).
    assign w_drained = w_tmo_hit
                     || ((w_count == '0) && !w_push)
                     || ((w_count == CNT_W'(1)) && w_pop && !w_push);

    sb_fifo #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_rd    (sb.exp_rd),
        .i_data  (sb.exp_data),
        .i_pop   (w_pop),
        .i_flush (w_tmo_hit),
        .o_rd    (w_head_rd),
        .o_data  (w_head_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Idle counter: runs only while entries wait with no retiring write.
    always_ff @(posedge clk) begin
        if (rst || !w_tmo_run || w_tmo_hit) r_tmo <= '0;
        else                                r_tmo <= r_tmo + 1'b1;
    end

    // Error count saturates; the capture registers freeze on the first error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_count  <= '0;
            r_fail_cause <= CAUSE_NONE;
            r_fail_rd    <= '0;
            r_fail_exp   <= '0;
            r_fail_got   <= '0;
        end else if (w_err) begin
            if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            if (r_err_count == '0) begin
                if (w_tmo_hit) begin
                    r_fail_cause <= CAUSE_TIMEOUT;
                    r_fail_rd    <= w_head_rd;
                    r_fail_exp   <= w_head_data;
                    r_fail_got   <= '0;
                end else if (w_unexp) begin
                    r_fail_cause <= CAUSE_UNEXP;
                    r_fail_rd    <= sb.wb_rd;
                    r_fail_exp   <= '0;
                    r_fail_got   <= sb.wb_data;
                end else begin
                    r_fail_cause <= CAUSE_MISMATCH;
                    r_fail_rd    <= sb.wb_rd;
                    r_fail_exp   <= w_head_data;
                    r_fail_got   <= sb.wb_data;
                end
            end
        end
    end

    // Run / drain / finish sequencing driven by the stimulus done flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (sb.done) r_state <= (w_count == '0) ? S_FINISH : S_DRAIN;
                end
                S_DRAIN: begin
                    if (w_drained) r_state <= S_FINISH;
                end
                default: r_state <= S_FINISH;
            endcase
        end
    end

    // Registered verdict taken from the already-registered state and error count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else begin
            r_pass <= w_finish && (r_err_count == '0);
            r_fail <= (r_err_count != '0);
        end
    end

    assign sb.pending    = w_count;
    assign sb.err_count  = r_err_count;
    assign sb.fail_cause = r_fail_cause;
    assign sb.fail_rd    = r_fail_rd;
    assign sb.fail_exp   = r_fail_exp;
    assign sb.fail_got   = r_fail_got;
    assign sb.pass       = r_pass;
    assign sb.fail       = r_fail;
endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed scenarios plus a randomized phase, all compared
// against a queue-based reference model of the scoreboard rules.
module tb_wb_scoreboard;
    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;
    localparam bit IGN_X0  = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_scoreboard_if #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH)) sb_if ();

    wb_scoreboard #(
        .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IGNORE_X0(IGN_X0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    typedef struct {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } ent_t;
    typedef enum {M_RUN, M_DRAIN, M_FIN} mstate_t;

    ent_t        mq[$];
    mstate_t     m_state;
    int          m_idle;
    int          m_errs;
    logic [1:0]  m_cause;
    logic [4:0]  m_rd;
    logic [31:0] m_exp;
    logic [31:0] m_got;
    logic        m_pass;
    logic        m_fail;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = M_RUN;
        m_idle  = 0;
        m_errs  = 0;
        m_cause = 0; m_rd = 0; m_exp = 0; m_got = 0;
        m_pass  = 0; m_fail = 0;
    endtask

    task automatic model_error(input logic [1:0] cause, input logic [4:0] rd,
                               input logic [31:0] e, input logic [31:0] g);
        if (m_errs == 0) begin
            m_cause = cause; m_rd = rd; m_exp = e; m_got = g;
        end
        if (m_errs < 65535) m_errs++;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        bit   ev, ready, push, flushed, done_in;
        int   pre_size, old_errs;
        ent_t h;
        ready = !rst && (mq.size() < DEPTH) && (m_state != M_FIN);
        check("exp_ready", sb_if.exp_ready, ready);
        if (rst) begin
            model_reset();
            return;
        end
        ev       = sb_if.wb_en && !(IGN_X0 && sb_if.wb_rd == 0);
        push     = sb_if.exp_valid && ready;
        done_in  = sb_if.done;
        pre_size = mq.size();
        old_errs = m_errs;
        flushed  = 0;
        if (ev) begin
            if (pre_size == 0 || m_state == M_FIN) begin
                model_error(2'd1, sb_if.wb_rd, 32'h0, sb_if.wb_data);
            end else begin
                h = mq.pop_front();
                if (h.rd != sb_if.wb_rd || h.data != sb_if.wb_data)
                    model_error(2'd2, sb_if.wb_rd, h.data, sb_if.wb_data);
            end
            m_idle = 0;
        end else if (pre_size != 0) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                model_error(2'd3, mq[0].rd, mq[0].data, 32'h0);
                mq.delete();
                m_idle  = 0;
                flushed = 1;
            end
        end else begin
            m_idle = 0;
        end
        if (push && !flushed) mq.push_back('{sb_if.exp_rd, sb_if.exp_data});
        m_pass = (m_state == M_FIN) && (old_errs == 0);
        m_fail = (old_errs != 0);
        case (m_state)
            M_RUN:   if (done_in) m_state = (pre_size == 0) ? M_FIN : M_DRAIN;
            M_DRAIN: if (mq.size() == 0) m_state = M_FIN;
            default: m_state = M_FIN;
        endcase
    endtask

    task automatic compare_outputs();
        check("pending",    sb_if.pending,    mq.size());
        check("err_count",  sb_if.err_count,  m_errs);
        check("fail_cause", sb_if.fail_cause, m_cause);
        check("fail_rd",    sb_if.fail_rd,    m_rd);
        check("fail_exp",   sb_if.fail_exp,   m_exp);
        check("fail_got",   sb_if.fail_got,   m_got);
        check("pass",       sb_if.pass,       m_pass);
        check("fail",       sb_if.fail,       m_fail);
    endtask

    task automatic tick();
        #1;
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic idle_in();
        sb_if.exp_valid = 0; sb_if.exp_rd = 0; sb_if.exp_data = 0;
        sb_if.wb_en = 0; sb_if.wb_rd = 0; sb_if.wb_data = 0; sb_if.done = 0;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        sb_if.exp_valid = 1; sb_if.exp_rd = rd; sb_if.exp_data = d;
        tick();
        sb_if.exp_valid = 0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        sb_if.wb_en = 1; sb_if.wb_rd = rd; sb_if.wb_data = d;
        tick();
        sb_if.wb_en = 0;
    endtask

    task automatic wb_head();
        if (mq.size() > 0) wb(mq[0].rd, mq[0].data);
        else check("head_available", 64'(mq.size()), 64'd1);
    endtask

    initial begin
        idle_in();
        model_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        check("reset_pending", sb_if.pending, 0);
        check("reset_errs",    sb_if.err_count, 0);
        check("reset_pass",    sb_if.pass, 0);

        // Three matching writes, then done.
        push(5'd1, 32'h00000032);
        push(5'd2, 32'hFFFFF814);
        push(5'd3, 32'hFFFFF846);
        wb(5'd1, 32'h00000032);
        wb(5'd2, 32'hFFFFF814);
        wb(5'd3, 32'hFFFFF846);
        sb_if.done = 1; tick(); sb_if.done = 0;
        tick();
        check("tp1_pass", sb_if.pass, 1);
        check("tp1_errs", sb_if.err_count, 0);
        check("tp1_pend", sb_if.pending, 0);

        // Data mismatch.
        do_reset();
        push(5'd4, 32'h00000816);
        wb(5'd4, 32'h00000815);
        tick();
        check("tp2_cause", sb_if.fail_cause, 2);
        check("tp2_exp",   sb_if.fail_exp, 32'h816);
        check("tp2_got",   sb_if.fail_got, 32'h815);
        check("tp2_errs",  sb_if.err_count, 1);
        check("tp2_fail",  sb_if.fail, 1);

        // x0 write ignored, then unexpected write.
        do_reset();
        wb(5'd0, 32'hDEADBEEF);
        check("tp3_x0_errs", sb_if.err_count, 0);
        wb(5'd5, 32'h1);
        check("tp3_cause", sb_if.fail_cause, 1);
        check("tp3_rd",    sb_if.fail_rd, 5);

        // Fill, hold a 17th offer, then stream through pointer wrap.
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(5'($urandom_range(1, 31)), $urandom);
        check("tp4_full_ready", sb_if.exp_ready, 0);
        sb_if.exp_valid = 1; sb_if.exp_rd = 5'd9; sb_if.exp_data = 32'h17;
        tick();
        check("tp4_held_pend", sb_if.pending, 16);
        sb_if.wb_en = 1; sb_if.wb_rd = mq[0].rd; sb_if.wb_data = mq[0].data;
        tick();
        sb_if.wb_en = 0;
        check("tp4_ready_after_pop", sb_if.exp_ready, 1);
        for (int i = 0; i < 40; i++) begin
            sb_if.exp_valid = 1; sb_if.exp_rd = 5'($urandom_range(1, 31)); sb_if.exp_data = $urandom;
            sb_if.wb_en = 1; sb_if.wb_rd = mq[0].rd; sb_if.wb_data = mq[0].data;
            tick();
        end
        idle_in();
        while (mq.size() > 0) wb_head();
        check("tp4_wrap_errs", sb_if.err_count, 0);

        // Hang timeout.
        do_reset();
        push(5'd7, 32'h77);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("tp5_no_tmo_yet", sb_if.fail_cause, 0);
        tick();
        check("tp5_cause", sb_if.fail_cause, 3);
        check("tp5_pend",  sb_if.pending, 0);
        check("tp5_errs",  sb_if.err_count, 1);

        // Mid-operation reset with pending entries and errors.
        do_reset();
        for (int i = 0; i < 7; i++) push(5'(i + 1), 32'(i * 3));
        wb(5'd1, 32'hBAD);
        wb(5'd2, 32'hBAD);
        check("tp6_pend_pre", sb_if.pending, 5);
        check("tp6_errs_pre", sb_if.err_count, 2);
        sb_if.exp_valid = 1; sb_if.exp_rd = 5'd3; sb_if.exp_data = 32'h3;
        rst = 1; tick(); rst = 0;
        sb_if.exp_valid = 0;
        check("tp6_pend",  sb_if.pending, 0);
        check("tp6_errs",  sb_if.err_count, 0);
        check("tp6_cause", sb_if.fail_cause, 0);
        check("tp6_fail",  sb_if.fail, 0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            sb_if.exp_valid = ($urandom_range(0, 99) < 50);
            sb_if.exp_rd    = 5'($urandom_range(0, 31));
            sb_if.exp_data  = $urandom;
            sb_if.wb_en     = ($urandom_range(0, 99) < 40);
            if (mq.size() > 0 && $urandom_range(0, 99) < 90) begin
                sb_if.wb_rd   = mq[0].rd;
                sb_if.wb_data = mq[0].data;
                if ($urandom_range(0, 99) < 5) sb_if.wb_data = mq[0].data ^ 32'h1;
            end else begin
                sb_if.wb_rd   = 5'($urandom_range(0, 31));
                sb_if.wb_data = $urandom;
            end
            sb_if.done = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 299) == 0) || (m_state == M_FIN && $urandom_range(0, 9) == 0);
            tick();
        end
        rst = 0;
        idle_in();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_scoreboard.md
# wb_scoreboard

In-order writeback scoreboard for the single-cycle core's self-checking benches, parametrised in data width, register count, queue depth and timeout. A stimulus source queues expected (rd, value) results. The block taps the register-file write port of `processor_top` and checks each retiring write against the queue head. It replaces end-of-run register peeks with per-write checking, failure capture and a hang timeout, and is synthesizable so it can also sit on-chip as a BIST monitor.

## Interface
- `XLEN`, 32, data width
- `REG_AW`, 5, register index width
- `DEPTH`, 16, expected-result queue entries; power of two, ≥2
- `TIMEOUT`, 64, idle cycles allowed with entries pending; ≥1
- `IGNORE_X0`, 1, when 1, writes to rd=0 are not checked
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `exp_valid` in 1: expected entry offered
- `exp_ready` out 1: entry accepted this cycle when high with `exp_valid`
- `exp_rd` in REG_AW: expected destination register
- `exp_data` in XLEN: expected write value
- `wb_en` in 1: register-file write enable (tapped)
- `wb_rd` in REG_AW: write index
- `wb_data` in XLEN: write data
- `done` in 1: stimulus finished (pulse or level)
- `pending` out $clog2(DEPTH)+1: queue occupancy
- `err_count` out 16: errors, saturating at 0xFFFF
- `fail_cause` out 2: first error; 0 none, 1 unexpected write, 2 mismatch, 3 timeout
- `fail_rd` out REG_AW, `fail_exp` out XLEN, `fail_got` out XLEN: first-error capture
- `pass` out 1, `fail` out 1: registered verdict

## Operation
- Check event: `wb_en && !(IGNORE_X0 && wb_rd==0)`.
- Push: `exp_valid && exp_ready`. `exp_ready = !full && state!=FINISH && !rst`. No push while full, even when a pop occurs in the same cycle.
- Event with queue empty: unexpected-write error, cause 1. Capture `wb_rd`, `fail_exp`=0 and `wb_data`.
- Event with queue non-empty: pop the head. Error cause 2 if `wb_rd!=head.rd` or `wb_data!=head.data`. The pop happens regardless of match.
- A push and an event in the same cycle on an empty queue count as unexpected. There is no bypass.
- Push and pop in the same cycle on a non-empty queue leave occupancy unchanged. Pointers wrap modulo DEPTH.
- Timeout counter:
  - Cleared on reset, on each event, and whenever the queue is empty.
  - Otherwise increments each cycle.
  - When it reaches TIMEOUT: cause 3 error, queue flushed (pending=0), counter cleared.
- Capture registers load only on the first error; later errors only increment `err_count`.
- FSM:
  - RUN (reset state): goes to DRAIN when `done` is seen and pending>0. Goes straight to FINISH when `done` is seen and pending=0.
  - DRAIN: goes to FINISH when pending reaches 0 by pop or flush.
  - FINISH: terminal until reset. No pushes. Events are still checked and always count as unexpected.
- Verdict:
  - `pass` = FINISH && err_count==0.
  - `fail` = err_count!=0, in any state.
  - Both are registered.

## Timing
- Reset values: all pointers and counters 0, `pending`=0, `err_count`=0, `fail_cause`=0, `fail_rd`/`fail_exp`/`fail_got`=0, `pass`=`fail`=0, state RUN.
- Push is visible in `pending` the next cycle. Event to `err_count`/capture update: 1 cycle.
- Event in cycle N with a queue pushed in cycle N-1: head is valid and gets checked.
- `fail` rises 2 cycles after the offending event (count update, then registered verdict). `pass` rises 1 cycle after FINISH entry.
- Timeout error registers in the cycle the counter equals TIMEOUT.
- `rst` mid-operation clears all state at that edge and drops any in-flight push. `exp_ready` is low during the reset cycle.

## Structure
- Shared package `wb_sb_pkg`: `fail_cause` encodings (`CAUSE_NONE`, `CAUSE_UNEXP`, `CAUSE_MISMATCH`, `CAUSE_TIMEOUT`) and the state enum (RUN, DRAIN, FINISH).
- One sub-module `sb_fifo`: parametrised sync FIFO of {rd, data}, with push/pop, full/empty, count and flush.
- Scoreboard top contains the FSM, timeout counter, comparator and capture.

## Test plan
- Push (1,0x00000032), (2,0xFFFFF814), (3,0xFFFFF846), then matching writebacks one per cycle, then `done` -> `pass`=1, `err_count`=0, `pending`=0.
- Expect (4,0x00000816), writeback (4,0x00000815) -> `fail_cause`=2, `fail_exp`=0x816, `fail_got`=0x815, `err_count`=1, `fail`=1.
- IGNORE_X0=1: writeback (0,0xDEADBEEF) ignored. Then with the queue empty, writeback (5,0x1) -> `fail_cause`=1, `fail_rd`=5.
- Push 16 entries -> `exp_ready`=0 and a 17th offer is held. One writeback pops -> `exp_ready`=1 next cycle. Pointer wrap verified over 40 entries.
- Push one entry, no writeback for 64 cycles -> `fail_cause`=3 at cycle 64, `pending`=0, `err_count`=1.
- With 5 pending and `err_count`=2, assert `rst` for one cycle -> all outputs at reset values after that edge, state RUN.
